// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit scheduler.
//                Holds the scheduler state encoding, the byte / burst-counter /
//                hold-timer widths, parameter range limits and small helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int c_byte_w  = 8;
    localparam int c_cnt_w   = 8;
    localparam int c_timer_w = 16;

    localparam int c_req_min     = 2;
    localparam int c_req_max     = 4;
    localparam int c_burst_max   = 255;
    localparam int c_timeout_max = 65535;

    // True when all scheduler parameters are inside their supported ranges.
    function automatic bit params_ok(input int n_req, input int burst_max,
                                     input int hold_timeout);
        return (n_req >= c_req_min) && (n_req <= c_req_max) &&
               (burst_max >= 1) && (burst_max <= c_burst_max) &&
               (hold_timeout >= 1) && (hold_timeout <= c_timeout_max);
    endfunction

    // Width of a requester index; never less than one bit.
    function automatic int idx_width(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Combinational round-robin pick. Selects the first asserted
//                request strictly after last_owner, wrapping around.
//  Ports       : req        - request vector, one bit per requester
//                last_owner - index of the most recent owner
//                pick       - one-hot winner (zero when no request)
//                pick_idx   - binary index of the winner
//                any        - at least one request is asserted
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ   = 3,
    localparam int c_idx_w = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [c_idx_w-1:0] last_owner,
    output logic [N_REQ-1:0]   pick,
    output logic [c_idx_w-1:0] pick_idx,
    output logic               any
);

    // One extra bit so last_owner + offset cannot overflow before the wrap.
    localparam logic [c_idx_w:0] c_n = (c_idx_w + 1)'(N_REQ);

    logic [c_idx_w:0]   w_sum;
    logic [c_idx_w-1:0] w_sel;
    logic               w_found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = |req;
        w_sum    = '0;
        w_sel    = '0;
        w_found  = 1'b0;
        // Offsets 1..N_REQ visit every requester once, the previous owner last.
        for (int off = 1; off <= N_REQ; off++) begin
            w_sum = {1'b0, last_owner} + (c_idx_w + 1)'(off);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            w_sel = w_sum[c_idx_w-1:0];
            if (!w_found && req[w_sel]) begin
                w_found     = 1'b1;
                pick[w_sel] = 1'b1;
                pick_idx    = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Shares one UART transmit path among N_REQ byte-stream
//                requesters. Grants round-robin, keeps the grant for a whole
//                message, forces rotation after BURST_MAX bytes and revokes a
//                stalled grant after HOLD_TIMEOUT idle cycles.
//  Ports       : sys_clk   - clock, rising edge
//                sys_rst   - synchronous reset, active low
//                en        - enable; low blocks new grants
//                req_valid / req_data / req_last - per-requester byte stream
//                req_ready - one-cycle accept pulse to the owner
//                grant     - one-hot owner, zero when idle
//                tx_data / tx_wr - byte and strobe to the transceiver
//                tx_done   - end-of-stop-bit pulse from the transceiver
//                busy      - scheduler not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int BURST_MAX    = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [8*N_REQ-1:0]    req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      grant,
    output logic [c_byte_w-1:0]   tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done,
    output logic                  busy
);

    localparam int                   c_idx_w  = idx_width(N_REQ);
    localparam logic [c_cnt_w-1:0]   c_burst  = c_cnt_w'(BURST_MAX);
    localparam logic [c_timer_w-1:0] c_hold   = c_timer_w'(HOLD_TIMEOUT);
    localparam logic [c_idx_w-1:0]   c_last_i = c_idx_w'(N_REQ - 1);

    generate
        if (!params_ok(N_REQ, BURST_MAX, HOLD_TIMEOUT)) begin : g_param_check
            $error("uart_tx_sched: parameter out of supported range");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_idx_w-1:0]   r_last_owner;
    logic [c_cnt_w-1:0]   r_byte_cnt;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_last_q;
    logic [N_REQ-1:0]     r_grant;
    logic [N_REQ-1:0]     r_req_ready;
    logic [c_byte_w-1:0]  r_tx_data;
    logic                 r_tx_wr;
    logic                 r_busy;

    logic [N_REQ-1:0]     w_pick;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_any;
    logic                 w_owner_valid;
    logic                 w_owner_last;
    logic [c_byte_w-1:0]  w_owner_data;
    logic                 w_burst_done;
    logic [c_timer_w-1:0] w_timer_inc;
    logic                 w_hold_expired;
    logic                 w_start;
    logic                 w_release;

    uart_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_owner (r_last_owner),
        .pick       (w_pick),
        .pick_idx   (w_pick_idx),
        .any        (w_any)
    );

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_owner_data  = req_data[8*r_owner +: 8];
    assign w_burst_done  = (r_byte_cnt == c_burst);
    assign w_timer_inc   = (r_timer == c_hold) ? r_timer : r_timer + 1'b1;
    // Compare the incremented value so HOLD lasts exactly HOLD_TIMEOUT cycles.
    assign w_hold_expired = (w_timer_inc == c_hold);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_state_next = SEND;
                    w_start      = 1'b1;
                end
            end
            SEND: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                // Only tx_done moves us on; a disable arriving with it releases.
                if (tx_done) begin
                    if (r_last_q || w_burst_done || !en) begin
                        w_state_next = IDLE;
                        w_release    = 1'b1;
                    end else if (w_owner_valid) begin
                        w_state_next = SEND;
                    end else begin
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_owner_valid && en) begin
                    w_state_next = SEND;
                end else if (!en || w_hold_expired) begin
                    w_state_next = IDLE;
                    w_release    = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_owner      <= '0;
            r_last_owner <= c_last_i;
            r_byte_cnt   <= '0;
            r_timer      <= '0;
            r_last_q     <= 1'b0;
            r_grant      <= '0;
            r_req_ready  <= '0;
            r_tx_data    <= '0;
            r_tx_wr      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tx_wr     <= 1'b0;
            r_req_ready <= '0;
            r_busy      <= (w_state_next != IDLE);

            if (w_start) begin
                r_grant    <= w_pick;
                r_owner    <= w_pick_idx;
                r_byte_cnt <= '0;
            end

            // Strobe, data and accept are registered out of the SEND cycle.
            if (r_state == SEND) begin
                r_tx_wr     <= 1'b1;
                r_tx_data   <= w_owner_data;
                r_req_ready <= r_grant;
                r_last_q    <= w_owner_last;
                r_byte_cnt  <= r_byte_cnt + 1'b1;
            end

            if (r_state == HOLD) begin
                r_timer <= w_timer_inc;
            end else if (w_state_next == HOLD) begin
                r_timer <= '0;
            end

            if (w_release) begin
                r_last_owner <= r_owner;
                r_grant      <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign grant     = r_grant;
    assign tx_data   = r_tx_data;
    assign tx_wr     = r_tx_wr;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Directed self-checking bench for uart_tx_sched with three
//                requesters, BURST_MAX=4 and HOLD_TIMEOUT=50. A requester
//                model feeds per-requester byte queues and a transceiver
//                model answers every tx_wr with tx_done 20 cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sys_rst   = 1'b0;
    logic         en        = 1'b0;
    logic [2:0]   req_valid = '0;
    logic [23:0]  req_data  = '0;
    logic [2:0]   req_last  = '0;
    wire  [2:0]   req_ready;
    wire  [2:0]   grant;
    wire  [7:0]   tx_data;
    wire          tx_wr;
    wire          tx_done;
    wire          busy;

    logic model_done  = 1'b0;
    logic manual_done = 1'b0;
    assign tx_done = model_done | manual_done;

    uart_tx_sched #(
        .N_REQ        (3),
        .BURST_MAX    (4),
        .HOLD_TIMEOUT (50)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done),
        .busy      (busy)
    );

    int assertions = 0;
    int failures   = 0;

    // Requester byte stores: tasks append (wr), the requester model consumes (rd).
    logic [8:0] mem [3][64];
    int wr [3] = '{0, 0, 0};
    int rd [3] = '{0, 0, 0};

    // Transceiver model and bus monitor.
    int          xc_cnt       = 0;
    int          overlap_cnt  = 0;
    int          nonowner_cnt = 0;
    int          rr_total     = 0;
    int          mon_bad      = 0;
    logic [2:0]  mon_expect   = 3'b000;
    logic [10:0] log_q [$];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && (rd[i] < wr[i])) rd[i]++;
            if (rd[i] < wr[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = mem[i][rd[i]][7:0];
                req_last[i]       = mem[i][rd[i]][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        model_done = 1'b0;
        if (xc_cnt > 0) begin
            xc_cnt--;
            if (xc_cnt == 0) model_done = 1'b1;
        end
        if (tx_wr) begin
            if (xc_cnt > 0) overlap_cnt++;
            xc_cnt = 20;
            log_q.push_back({grant, tx_data});
        end
        if (busy && (grant !== mon_expect)) mon_bad++;
        if (req_ready != 3'b000) rr_total++;
        if ((req_ready & ~grant) != 3'b000) nonowner_cnt++;
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][wr[r]] = {l, d};
        wr[r]++;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (!busy && !tx_wr && (xc_cnt == 0) && (rd[0] == wr[0]) &&
                (rd[1] == wr[1]) && (rd[2] == wr[2])) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        en      = 1'b1;
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b1;
        @(negedge clk);
        assertions++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant: got %b expected 000", grant); end
        assertions++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
        assertions++; if (tx_wr !== 1'b0) begin failures++; $display("FAIL reset_tx_wr: got %b expected 0", tx_wr); end
        assertions++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int base;
        bit ok;
        logic [10:0] exp_q [6];
        logic [10:0] got;
        exp_q = '{ {3'b001, 8'hA0}, {3'b010, 8'hA1}, {3'b100, 8'hA2},
                   {3'b001, 8'hA0}, {3'b010, 8'hA1}, {3'b100, 8'hA2} };
        base = log_q.size();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            push(0, 8'hA0, 1'b1);
            push(1, 8'hA1, 1'b1);
            push(2, 8'hA2, 1'b1);
            wait_drain(400, ok);
            assertions++; if (!ok) begin failures++; $display("FAIL rr_drain round %0d: got timeout expected idle", r); end
        end
        assertions++; if (log_q.size() - base != 6) begin failures++; $display("FAIL rr_count: got %0d expected 6", log_q.size() - base); end
        for (int k = 0; k < 6; k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 11'bx;
            assertions++; if (got !== exp_q[k]) begin failures++; $display("FAIL rr_byte %0d: got grant/data %h expected %h", k, got, exp_q[k]); end
        end
    endtask

    task automatic test_single_message();
        int base;
        int bad0;
        int cyc;
        bit ok;
        logic [10:0] exp_q [3];
        logic [10:0] got;
        exp_q = '{ {3'b010, 8'h41}, {3'b010, 8'h42}, {3'b010, 8'h43} };
        base       = log_q.size();
        bad0       = mon_bad;
        mon_expect = 3'b010;
        @(posedge clk); #1;
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (tx_wr) break;
        end
        // Drive lands on the first negedge, tx_wr is visible on the third.
        assertions++; if (cyc != 3) begin failures++; $display("FAIL single_latency: got %0d expected 3", cyc); end
        assertions++; if (req_ready !== 3'b010) begin failures++; $display("FAIL single_req_ready: got %b expected 010", req_ready); end
        wait_drain(300, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL single_drain: got timeout expected idle"); end
        assertions++; if (log_q.size() - base != 3) begin failures++; $display("FAIL single_count: got %0d expected 3", log_q.size() - base); end
        for (int k = 0; k < 3; k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 11'bx;
            assertions++; if (got !== exp_q[k]) begin failures++; $display("FAIL single_byte %0d: got %h expected %h", k, got, exp_q[k]); end
        end
        assertions++; if (mon_bad != bad0) begin failures++; $display("FAIL single_grant_held: got %0d off-grant cycles expected 0", mon_bad - bad0); end
        assertions++; if (grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL single_release: got grant %b busy %b expected 000 0", grant, busy); end
    endtask

    task automatic test_burst_cap();
        int base;
        bit ok;
        logic [10:0] exp_q [11];
        logic [10:0] got;
        for (int k = 0; k < 4; k++) exp_q[k] = {3'b001, 8'h10 + 8'(k)};
        exp_q[4] = {3'b100, 8'hEE};
        for (int k = 4; k < 10; k++) exp_q[k+1] = {3'b001, 8'h10 + 8'(k)};
        base = log_q.size();
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) push(0, 8'h10 + 8'(k), (k == 9));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_wr) break;
        end
        @(posedge clk); #1;
        push(2, 8'hEE, 1'b1);
        wait_drain(800, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL burst_drain: got timeout expected idle"); end
        assertions++; if (log_q.size() - base != 11) begin failures++; $display("FAIL burst_count: got %0d expected 11", log_q.size() - base); end
        for (int k = 0; k < 11; k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 11'bx;
            assertions++; if (got !== exp_q[k]) begin failures++; $display("FAIL burst_byte %0d: got %h expected %h", k, got, exp_q[k]); end
        end
    endtask

    task automatic test_hold_timeout();
        int base;
        int wr_seen;
        int cyc;
        bit pushed1;
        bit ok;
        logic [10:0] exp_q [6];
        logic [10:0] got;
        exp_q = '{ {3'b001, 8'h31}, {3'b001, 8'h32}, {3'b010, 8'h71},
                   {3'b001, 8'h33}, {3'b001, 8'h34}, {3'b001, 8'h35} };
        base = log_q.size();
        @(posedge clk); #1;
        push(0, 8'h31, 1'b0);
        push(0, 8'h32, 1'b0);
        wr_seen = 0;
        cyc     = 0;
        pushed1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (wr_seen >= 2) begin
                cyc++;
                if (grant !== 3'b001) break;
            end
            if (tx_wr) wr_seen++;
            if (wr_seen == 1 && !pushed1) begin
                push(1, 8'h71, 1'b1);
                pushed1 = 1'b1;
            end
        end
        // 20 cycles to tx_done, then 50 cycles of HOLD before the release shows.
        assertions++; if (cyc < 68 || cyc > 74) begin failures++; $display("FAIL hold_duration: got %0d expected 71 (68..74)", cyc); end
        assertions++; if (grant !== 3'b000) begin failures++; $display("FAIL hold_release: got grant %b expected 000", grant); end
        @(negedge clk);
        assertions++; if (grant !== 3'b010) begin failures++; $display("FAIL hold_next_owner: got grant %b expected 010", grant); end
        @(posedge clk); #1;
        push(0, 8'h33, 1'b0);
        push(0, 8'h34, 1'b0);
        push(0, 8'h35, 1'b1);
        wait_drain(500, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL hold_drain: got timeout expected idle"); end
        for (int k = 0; k < 6; k++) begin
            got = (base + k < log_q.size()) ? log_q[base + k] : 11'bx;
            assertions++; if (got !== exp_q[k]) begin failures++; $display("FAIL hold_byte %0d: got %h expected %h", k, got, exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid_message();
        int snap;
        bit seen;
        bit ok;
        logic [10:0] got;
        @(posedge clk); #1;
        push(1, 8'h51, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_wr) break;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1 sys_rst = 1'b0;
        @(posedge clk); #1 sys_rst = 1'b1;
        @(negedge clk);
        assertions++; if (grant !== 3'b000) begin failures++; $display("FAIL midrst_grant: got %b expected 000", grant); end
        assertions++; if (req_ready !== 3'b000) begin failures++; $display("FAIL midrst_req_ready: got %b expected 000", req_ready); end
        assertions++; if (tx_wr !== 1'b0) begin failures++; $display("FAIL midrst_tx_wr: got %b expected 0", tx_wr); end
        assertions++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_tx_data: got %h expected 00", tx_data); end
        assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        snap = log_q.size();
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (tx_done) begin seen = 1'b1; break; end
        end
        assertions++; if (!seen) begin failures++; $display("FAIL midrst_stale_done: got none expected a tx_done"); end
        repeat (3) @(negedge clk);
        assertions++; if (busy !== 1'b0 || grant !== 3'b000 || log_q.size() != snap) begin
            failures++; $display("FAIL midrst_done_ignored: got busy %b grant %b new_wr %0d expected 0 000 0", busy, grant, log_q.size() - snap);
        end
        @(posedge clk); #1;
        push(0, 8'h60, 1'b1);
        push(1, 8'h61, 1'b1);
        wait_drain(300, ok);
        assertions++; if (!ok) begin failures++; $display("FAIL midrst_drain: got timeout expected idle"); end
        got = (snap < log_q.size()) ? log_q[snap] : 11'bx;
        assertions++; if (got !== {3'b001, 8'h60}) begin failures++; $display("FAIL midrst_first_owner: got %h expected %h", got, {3'b001, 8'h60}); end
        got = (snap + 1 < log_q.size()) ? log_q[snap + 1] : 11'bx;
        assertions++; if (got !== {3'b010, 8'h61}) begin failures++; $display("FAIL midrst_second_owner: got %h expected %h", got, {3'b010, 8'h61}); end
    endtask

    task automatic test_spurious_done();
        int rr0;
        int snap;
        rr0  = rr_total;
        snap = log_q.size();
        @(posedge clk); #1 manual_done = 1'b1;
        @(posedge clk); #1 manual_done = 1'b0;
        repeat (3) @(negedge clk);
        assertions++; if (busy !== 1'b0 || grant !== 3'b000) begin failures++; $display("FAIL spurious_state: got busy %b grant %b expected 0 000", busy, grant); end
        assertions++; if (rr_total != rr0) begin failures++; $display("FAIL spurious_req_ready: got %0d pulses expected 0", rr_total - rr0); end
        assertions++; if (log_q.size() != snap) begin failures++; $display("FAIL spurious_tx_wr: got %0d strobes expected 0", log_q.size() - snap); end
        assertions++; if (overlap_cnt != 0) begin failures++; $display("FAIL in_flight_tx_wr: got %0d expected 0", overlap_cnt); end
        assertions++; if (nonowner_cnt != 0) begin failures++; $display("FAIL nonowner_req_ready: got %0d expected 0", nonowner_cnt); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_message();
        test_burst_cap();
        test_hold_timeout();
        test_reset_mid_message();
        test_spurious_done();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
